// File: rtl/cc_pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM state encoding
// and the all-ones saturation constant that each instance slices to its width.
package cc_pwm_capture_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int          SAT_MAX_W = 64;
    localparam logic [SAT_MAX_W-1:0] SAT_ALL = {SAT_MAX_W{1'b1}};

endpackage

// File: rtl/cc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by an edge register;
// rise_Out/fall_Out are single-cycle pulses on synchronized transitions.
module cc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise_Out,
    output logic fall_Out
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            last <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            last <= sync[SYNC_STAGES-1];
        end
    end

    assign rise_Out = sync[SYNC_STAGES-1] & ~last;
    assign fall_Out = ~sync[SYNC_STAGES-1] & last;

endmodule

// File: rtl/cc_pwm_capture.sv
// PWM pulse decoder: measures high time and period in clock cycles and hands
// results out over valid/ack. Define CC_PWMCAPTURE_COMPARE_EN for the threshold comparator.
module cc_pwm_capture
    import cc_pwm_capture_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = 16,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        CC_PWMCAPTURE_CLOCK_50,
    input  logic                        CC_PWMCAPTURE_RESET_InLow,
    input  logic                        CC_PWMCAPTURE_enable_In,
    input  logic                        CC_PWMCAPTURE_pwm_In,
    input  logic                        CC_PWMCAPTURE_ack_In,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_PWMCAPTURE_threshold_InBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_PWMCAPTURE_high_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_PWMCAPTURE_period_OutBUS,
    output logic                        CC_PWMCAPTURE_valid_Out,
    output logic                        CC_PWMCAPTURE_overflow_Out,
    output logic                        CC_PWMCAPTURE_above_Out
);

    localparam int            W   = NUMBER_DATAWIDTH;
    localparam logic [W-1:0]  SAT = SAT_ALL[W-1:0];

    state_t         state;
    logic [W-1:0]   cnt;
    logic           rise;
    logic           fall;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == SAT) ? SAT : v + W'(1);
    endfunction

    cc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (CC_PWMCAPTURE_CLOCK_50),
        .rst_n    (CC_PWMCAPTURE_RESET_InLow),
        .pin      (CC_PWMCAPTURE_pwm_In),
        .rise_Out (rise),
        .fall_Out (fall)
    );

    // One counter runs from the start rise: its value at the fall is the high
    // time and at the next rise is the period.
    always_ff @(posedge CC_PWMCAPTURE_CLOCK_50 or negedge CC_PWMCAPTURE_RESET_InLow) begin
        if (!CC_PWMCAPTURE_RESET_InLow) begin
            state                       <= IDLE;
            cnt                         <= '0;
            CC_PWMCAPTURE_high_OutBUS   <= '0;
            CC_PWMCAPTURE_period_OutBUS <= '0;
            CC_PWMCAPTURE_valid_Out     <= 1'b0;
            CC_PWMCAPTURE_overflow_Out  <= 1'b0;
        end else if (!CC_PWMCAPTURE_enable_In) begin
            state                   <= IDLE;
            CC_PWMCAPTURE_valid_Out <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= ARM;
                ARM: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= W'(1);
                    end
                end
                HIGH: begin
                    if (cnt == SAT) begin
                        state                       <= DONE;
                        CC_PWMCAPTURE_high_OutBUS   <= SAT;
                        CC_PWMCAPTURE_period_OutBUS <= SAT;
                        CC_PWMCAPTURE_overflow_Out  <= 1'b1;
                        CC_PWMCAPTURE_valid_Out     <= 1'b1;
                    end else if (fall) begin
                        state                     <= LOW;
                        CC_PWMCAPTURE_high_OutBUS <= cnt;
                        cnt                       <= sat_inc(cnt);
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                LOW: begin
                    if (cnt == SAT) begin
                        state                       <= DONE;
                        CC_PWMCAPTURE_period_OutBUS <= SAT;
                        CC_PWMCAPTURE_overflow_Out  <= 1'b1;
                        CC_PWMCAPTURE_valid_Out     <= 1'b1;
                    end else if (rise) begin
                        state                       <= DONE;
                        CC_PWMCAPTURE_period_OutBUS <= cnt;
                        CC_PWMCAPTURE_overflow_Out  <= 1'b0;
                        CC_PWMCAPTURE_valid_Out     <= 1'b1;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                DONE: begin
                    // A rise arriving with ack is swallowed here, so the next
                    // measurement always needs a fresh rise seen in ARM.
                    if (CC_PWMCAPTURE_ack_In) begin
                        state                   <= ARM;
                        CC_PWMCAPTURE_valid_Out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CC_PWMCAPTURE_COMPARE_EN
    logic           enter_done;
    logic [W-1:0]   high_next;

    // Mirror the FSM's DONE entry so the compare result lands with valid.
    always_comb begin
        enter_done = 1'b0;
        high_next  = CC_PWMCAPTURE_high_OutBUS;
        if (CC_PWMCAPTURE_enable_In) begin
            case (state)
                HIGH: begin
                    enter_done = (cnt == SAT);
                    high_next  = SAT;
                end
                LOW:     enter_done = (cnt == SAT) || rise;
                default: enter_done = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CC_PWMCAPTURE_CLOCK_50 or negedge CC_PWMCAPTURE_RESET_InLow) begin
        if (!CC_PWMCAPTURE_RESET_InLow) begin
            CC_PWMCAPTURE_above_Out <= 1'b0;
        end else if (enter_done) begin
            CC_PWMCAPTURE_above_Out <= (high_next > CC_PWMCAPTURE_threshold_InBUS);
        end
    end
`else
    logic unused_threshold;
    assign unused_threshold        = ^CC_PWMCAPTURE_threshold_InBUS;
    assign CC_PWMCAPTURE_above_Out = 1'b0;
`endif

endmodule

// File: tb/tb_cc_pwm_capture.sv
// Scoreboard bench for cc_pwm_capture: a 16-bit and an 8-bit instance, directed
// pulses with hand-computed expected results queued and checked on valid rise.
module tb_cc_pwm_capture;

`ifdef CC_PWMCAPTURE_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    typedef struct {
        int high;
        int period;
        bit ovf;
        bit above;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en16, pwm16, ack16;
    logic [15:0] thr16, high16, per16;
    logic        valid16, ovf16, above16;
    logic        en8, pwm8, ack8;
    logic [7:0]  thr8, high8, per8;
    logic        valid8, ovf8, above8;

    exp_t q16[$];
    exp_t q8[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic v16_d  = 1'b0;
    logic v8_d   = 1'b0;

    always #5 clk = ~clk;

    cc_pwm_capture #(.NUMBER_DATAWIDTH(16), .SYNC_STAGES(2)) dut16 (
        .CC_PWMCAPTURE_CLOCK_50        (clk),
        .CC_PWMCAPTURE_RESET_InLow     (rst_n),
        .CC_PWMCAPTURE_enable_In       (en16),
        .CC_PWMCAPTURE_pwm_In          (pwm16),
        .CC_PWMCAPTURE_ack_In          (ack16),
        .CC_PWMCAPTURE_threshold_InBUS (thr16),
        .CC_PWMCAPTURE_high_OutBUS     (high16),
        .CC_PWMCAPTURE_period_OutBUS   (per16),
        .CC_PWMCAPTURE_valid_Out       (valid16),
        .CC_PWMCAPTURE_overflow_Out    (ovf16),
        .CC_PWMCAPTURE_above_Out       (above16)
    );

    cc_pwm_capture #(.NUMBER_DATAWIDTH(8), .SYNC_STAGES(2)) dut8 (
        .CC_PWMCAPTURE_CLOCK_50        (clk),
        .CC_PWMCAPTURE_RESET_InLow     (rst_n),
        .CC_PWMCAPTURE_enable_In       (en8),
        .CC_PWMCAPTURE_pwm_In          (pwm8),
        .CC_PWMCAPTURE_ack_In          (ack8),
        .CC_PWMCAPTURE_threshold_InBUS (thr8),
        .CC_PWMCAPTURE_high_OutBUS     (high8),
        .CC_PWMCAPTURE_period_OutBUS   (per8),
        .CC_PWMCAPTURE_valid_Out       (valid8),
        .CC_PWMCAPTURE_overflow_Out    (ovf8),
        .CC_PWMCAPTURE_above_Out       (above8)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int h, input int p, input bit o, input int thr);
        exp_t e;
        e.high   = h;
        e.period = p;
        e.ovf    = o;
        e.above  = CMP && (h > thr);
        return e;
    endfunction

    // Monitors: compare the head of each queue when valid rises.
    always @(negedge clk) begin
        if (valid16 && !v16_d) begin
            if (q16.size() == 0) begin
                check("dut16 unexpected result", 1, 0);
            end else begin
                check("dut16 high", high16, q16[0].high);
                check("dut16 period", per16, q16[0].period);
                check("dut16 overflow", ovf16, q16[0].ovf);
                check("dut16 above", above16, q16[0].above);
                void'(q16.pop_front());
            end
        end
        v16_d <= valid16;
    end

    always @(negedge clk) begin
        if (valid8 && !v8_d) begin
            if (q8.size() == 0) begin
                check("dut8 unexpected result", 1, 0);
            end else begin
                check("dut8 high", high8, q8[0].high);
                check("dut8 period", per8, q8[0].period);
                check("dut8 overflow", ovf8, q8[0].ovf);
                check("dut8 above", above8, q8[0].above);
                void'(q8.pop_front());
            end
        end
        v8_d <= valid8;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid16(input int limit);
        for (int i = 0; i < limit && !valid16; i++) @(negedge clk);
        if (!valid16) check("dut16 valid timeout", 0, 1);
    endtask

    task automatic wait_valid8(input int limit);
        for (int i = 0; i < limit && !valid8; i++) @(negedge clk);
        if (!valid8) check("dut8 valid timeout", 0, 1);
    endtask

    task automatic pulse16(input int h, input int l);
        pwm16 = 1'b1;
        cyc(h);
        pwm16 = 1'b0;
        cyc(l);
        pwm16 = 1'b1;
    endtask

    task automatic finish16();
        pwm16 = 1'b0;
        cyc(6);
        ack16 = 1'b1;
        cyc(1);
        ack16 = 1'b0;
        check("dut16 valid after ack", valid16, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        rst_n = 1'b0;
        en16  = 1'b0; pwm16 = 1'b0; ack16 = 1'b0; thr16 = 16'd9;
        en8   = 1'b0; pwm8  = 1'b0; ack8  = 1'b0; thr8  = 8'd100;
        cyc(2);
        check("reset valid16", valid16, 0);
        check("reset high16", high16, 0);
        check("reset period16", per16, 0);
        check("reset overflow16", ovf16, 0);
        check("reset above16", above16, 0);
        check("reset valid8", valid8, 0);
        rst_n = 1'b1;
        en16  = 1'b1;
        cyc(5);

        // Basic pulse: high 10, low 15.
        q16.push_back(mk(10, 25, 1'b0, 9));
        pulse16(10, 15);
        wait_valid16(20);

        // Result must stay frozen while unacknowledged, pwm still toggling.
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            pwm16 = ((i / 5) % 2) == 0;
            cyc(1);
            if (!valid16 || high16 != 16'd10 || per16 != 16'd25) drops++;
        end
        check("dut16 frozen cycles disturbed", drops, 0);
        check("dut16 valid held", valid16, 1);
        finish16();

        // Threshold equal to high time: not above.
        thr16 = 16'd10;
        cyc(3);
        q16.push_back(mk(10, 15, 1'b0, 10));
        pulse16(10, 5);
        wait_valid16(20);
        finish16();

        // Drop enable mid-HIGH, re-enable with pin already high.
        pwm16 = 1'b1;
        cyc(8);
        en16 = 1'b0;
        cyc(1);
        check("dut16 valid after disable", valid16, 0);
        check("dut16 high kept after disable", high16, 10);
        check("dut16 period kept after disable", per16, 15);
        en16 = 1'b1;
        cyc(30);
        check("dut16 no capture with level high", valid16, 0);
        pwm16 = 1'b0;
        cyc(4);
        q16.push_back(mk(6, 10, 1'b0, 10));
        pulse16(6, 4);
        wait_valid16(20);
        finish16();

        // Asynchronous reset in the middle of the low phase.
        pwm16 = 1'b1;
        cyc(4);
        pwm16 = 1'b0;
        cyc(6);
        rst_n = 1'b0;
        #1;
        check("async reset high16", high16, 0);
        check("async reset period16", per16, 0);
        check("async reset valid16", valid16, 0);
        check("async reset overflow16", ovf16, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        q16.push_back(mk(4, 9, 1'b0, 10));
        pulse16(4, 5);
        wait_valid16(20);
        finish16();

        // 8-bit instance: a long high saturates without any fall.
        en8 = 1'b1;
        cyc(3);
        q8.push_back(mk(255, 255, 1'b1, 100));
        pwm8 = 1'b1;
        wait_valid8(400);
        cyc(5);
        check("dut8 valid held while saturated", valid8, 1);
        check("dut8 high held while saturated", high8, 255);

        cyc(5);
        check("dut16 queue drained", q16.size(), 0);
        check("dut8 queue drained", q8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
